// File: rtl/fb_swap_scheduler_pkg.sv
// Shared types and width helpers for the frame-buffer swap scheduler.
package gpu_fb_pkg;

  typedef enum logic [1:0] {
    ST_RENDER    = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_FLIP      = 2'd2,
    ST_CLEAR     = 2'd3
  } fb_state_t;

  // Minimum index width for n entries (never below 1 bit).
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic int clr_cnt_width(input int size);
    return idx_width(size);
  endfunction

endpackage

// File: rtl/fb_swap_scheduler_if.sv
// Requester, sequencing and SRAM-side signals of the swap scheduler.
interface fb_swap_scheduler_if #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 1
);
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0][ADDR_SIZE-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]                req_ready;
  logic                              frame_done;
  logic                              vsync;
  logic                              sram_we;
  logic [ADDR_SIZE-1:0]              sram_addr;
  logic [DATA_SIZE-1:0]              sram_data;
  logic                              sram_flip;
  logic                              front_buf;
  logic                              busy;
  logic                              overrun;

  modport master (
    output req_valid, req_addr, req_data, frame_done, vsync,
    input  req_ready, sram_we, sram_addr, sram_data, sram_flip,
           front_buf, busy, overrun
  );

  modport slave (
    input  req_valid, req_addr, req_data, frame_done, vsync,
    output req_ready, sram_we, sram_addr, sram_data, sram_flip,
           front_buf, busy, overrun
  );
endinterface

// File: rtl/fb_swap_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the priority pointer.
module rr_arbiter import gpu_fb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               accept
);

  logic [IW-1:0] ptr;

  always_comb begin
    logic [IW:0] idx;
    gnt     = '0;
    gnt_idx = ptr;
    accept  = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
      if (en && !accept && req[idx[IW-1:0]]) begin
        gnt[idx[IW-1:0]] = 1'b1;
        gnt_idx          = idx[IW-1:0];
        accept           = 1'b1;
      end
    end
  end

  // Grant is only ever given to a valid requester, so a grant is a transfer.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fb_swap_scheduler.sv
// Double-buffer swap scheduler: arbitrates pixel writes and flips on vsync.
// Optional post-flip back-buffer clear is enabled by FB_CLEAR_ON_FLIP_EN.
//
// state        | meaning
// ST_RENDER    | requesters granted round-robin into the back buffer
// ST_WAIT_SYNC | frame complete, writes blocked until vsync
// ST_FLIP      | one-cycle sram_flip strobe, front_buf toggles
// ST_CLEAR     | back buffer filled with CLEAR_VALUE (feature build only)
module fb_swap_scheduler import gpu_fb_pkg::*; #(
  parameter int                   NUM_REQ     = 4,
  parameter int                   ADDR_SIZE   = 8,
  parameter int                   DATA_SIZE   = 1,
  parameter int                   SIZE        = 256,
  parameter logic [DATA_SIZE-1:0] CLEAR_VALUE = '0
) (
  input logic               clk,
  input logic               n_rst,
  fb_swap_scheduler_if.slave bus
);

  localparam int IW = idx_width(NUM_REQ);

  fb_state_t          state, state_nxt;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               accept;

`ifdef FB_CLEAR_ON_FLIP_EN
  localparam int CW = clr_cnt_width(SIZE);
  logic [CW-1:0] clr_cnt;
  logic          clr_last;

  assign clr_last = (clr_cnt == CW'(SIZE-1));
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .clk     (clk),
    .n_rst   (n_rst),
    .en      (state == ST_RENDER),
    .req     (bus.req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .accept  (accept)
  );

  assign bus.req_ready = gnt;
  assign bus.sram_flip = (state == ST_FLIP);
  assign bus.busy      = (state != ST_RENDER);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_RENDER;
    else        state <= state_nxt;
  end

  // A vsync coinciding with frame_done in RENDER is dropped: only WAIT_SYNC listens.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RENDER:    if (bus.frame_done) state_nxt = ST_WAIT_SYNC;
      ST_WAIT_SYNC: if (bus.vsync)      state_nxt = ST_FLIP;
`ifdef FB_CLEAR_ON_FLIP_EN
      ST_FLIP:      state_nxt = ST_CLEAR;
      ST_CLEAR:     if (clr_last)       state_nxt = ST_RENDER;
`else
      ST_FLIP:      state_nxt = ST_RENDER;
`endif
      default:      state_nxt = ST_RENDER;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus.sram_we   <= 1'b0;
      bus.sram_addr <= '0;
      bus.sram_data <= '0;
    end else begin
      bus.sram_we <= 1'b0;
      if (accept) begin
        bus.sram_we   <= 1'b1;
        bus.sram_addr <= bus.req_addr[gnt_idx];
        bus.sram_data <= bus.req_data[gnt_idx];
      end
`ifdef FB_CLEAR_ON_FLIP_EN
      else if (state == ST_CLEAR) begin
        bus.sram_we   <= 1'b1;
        bus.sram_addr <= ADDR_SIZE'(clr_cnt);
        bus.sram_data <= CLEAR_VALUE;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus.front_buf <= 1'b1;
      bus.overrun   <= 1'b0;
    end else begin
      if (state == ST_FLIP)                        bus.front_buf <= ~bus.front_buf;
      if (bus.frame_done && (state != ST_RENDER)) bus.overrun   <= 1'b1;
    end
  end

`ifdef FB_CLEAR_ON_FLIP_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                clr_cnt <= '0;
    else if (state != ST_CLEAR) clr_cnt <= '0;
    else if (!clr_last)         clr_cnt <= clr_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fb_swap_scheduler.sv
// Scoreboard bench for fb_swap_scheduler: expected SRAM writes are queued by
// the stimulus and popped by an independent monitor.
module tb_fb_swap_scheduler;

  localparam int         NUM_REQ     = 4;
  localparam int         ADDR_SIZE   = 8;
  localparam int         DATA_SIZE   = 1;
  localparam int         SIZE        = 256;
  localparam logic [0:0] CLEAR_VALUE = 1'b0;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  fb_swap_scheduler_if #(.NUM_REQ(NUM_REQ), .ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE)) bus ();

  fb_swap_scheduler #(
    .NUM_REQ(NUM_REQ), .ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE),
    .SIZE(SIZE), .CLEAR_VALUE(CLEAR_VALUE)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  int vec_cnt  = 0;
  int err_cnt  = 0;
  int flip_cnt = 0;
  logic [ADDR_SIZE+DATA_SIZE-1:0] exp_q[$];

  // Monitor: every SRAM write must match the head of the expected queue.
  initial begin
    logic [ADDR_SIZE+DATA_SIZE-1:0] e;
    forever begin
      @(negedge clk);
      if (bus.sram_flip) flip_cnt++;
      if (bus.sram_we) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL sram_write unexpected: addr=%0h data=%0h, none required",
                   bus.sram_addr, bus.sram_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.sram_addr, bus.sram_data} !== e) begin
            err_cnt++;
            $display("FAIL sram_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                     bus.sram_addr, bus.sram_data, e[ADDR_SIZE+DATA_SIZE-1:DATA_SIZE],
                     e[DATA_SIZE-1:0]);
          end
        end
      end
    end
  end

  task automatic check1(input string nm, input logic act, input logic exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b, required %b", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // One cycle: sample at negedge, queue the expected write, return at posedge+1.
  task automatic chk_cycle(input string nm, input logic [NUM_REQ-1:0] exp_rdy,
                           input int exp_we);
    @(negedge clk);
    vec_cnt++;
    if (bus.req_ready !== exp_rdy) begin
      err_cnt++;
      $display("FAIL %s req_ready: got %b, required %b", nm, bus.req_ready, exp_rdy);
    end
    if (exp_we >= 0) check1({nm, " sram_we"}, bus.sram_we, exp_we[0]);
    for (int i = 0; i < NUM_REQ; i++)
      if (exp_rdy[i]) exp_q.push_back({bus.req_addr[i], bus.req_data[i]});
    @(posedge clk);
    #1;
  endtask

  // Wait out the post-flip interval (clear pass in the feature build) until RENDER.
  task automatic wait_render(input string nm);
    int n;
`ifdef FB_CLEAR_ON_FLIP_EN
    for (int a = 0; a < SIZE; a++) exp_q.push_back({ADDR_SIZE'(a), CLEAR_VALUE});
`endif
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check1({nm, " back_to_render(busy)"}, bus.busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid  = '0;
    bus.frame_done = 1'b0;
    bus.vsync      = 1'b0;
  endtask

  initial begin
    int f0;
    idle_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_addr[i] = 8'h20 + 8'(i);
      bus.req_data[i] = 1'(i);
    end

    // Reset state
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    check1("rst sram_we", bus.sram_we, 1'b0);
    check_int("rst sram_addr", int'(bus.sram_addr), 0);
    check1("rst sram_data", bus.sram_data, 1'b0);
    check1("rst sram_flip", bus.sram_flip, 1'b0);
    check1("rst front_buf", bus.front_buf, 1'b1);
    check1("rst overrun", bus.overrun, 1'b0);
    check1("rst busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    n_rst = 1'b1;

    // All valid: grants 0,1,2,3,0 with a write every cycle after the first
    bus.req_valid = 4'b1111;
    chk_cycle("rr0", 4'b0001, 0);
    chk_cycle("rr1", 4'b0010, 1);
    chk_cycle("rr2", 4'b0100, 1);
    chk_cycle("rr3", 4'b1000, 1);
    chk_cycle("rr4", 4'b0001, 1);

    // Only requester 2 valid, addr 0x10 data 1
    bus.req_valid   = 4'b0100;
    bus.req_addr[2] = 8'h10;
    bus.req_data[2] = 1'b1;
    chk_cycle("solo2", 4'b0100, 1);
    bus.req_valid = '0;
    chk_cycle("solo2_wr", 4'b0000, 1);
    chk_cycle("idle", 4'b0000, 0);

    // Pointer is now 3: wrap from 3 to 0
    bus.req_valid = 4'b1001;
    chk_cycle("wrap3", 4'b1000, 0);
    chk_cycle("wrap0", 4'b0001, 1);

    // frame_done with a same-cycle grant, vsync 5 cycles later
    f0 = flip_cnt;
    bus.req_valid  = 4'b0010;
    bus.frame_done = 1'b1;
    chk_cycle("fd_grant", 4'b0010, 1);
    bus.frame_done = 1'b0;
    bus.req_valid  = 4'b1111;
    chk_cycle("wait1", 4'b0000, 1);
    check1("wait busy", bus.busy, 1'b1);
    for (int c = 2; c <= 4; c++) chk_cycle("wait", 4'b0000, 0);
    bus.vsync = 1'b1;
    chk_cycle("wait_vsync", 4'b0000, 0);
    idle_inputs();
    @(negedge clk);
    check1("flip strobe", bus.sram_flip, 1'b1);
    check1("flip front_buf_before", bus.front_buf, 1'b1);
    @(posedge clk); #1;
    wait_render("flip1");
    check1("flip1 front_buf", bus.front_buf, 1'b0);
    check_int("flip1 count", flip_cnt - f0, 1);
    check1("flip1 overrun", bus.overrun, 1'b0);

    // frame_done and vsync together: that vsync is dropped
    f0 = flip_cnt;
    bus.frame_done = 1'b1;
    bus.vsync      = 1'b1;
    chk_cycle("fdvs", 4'b0000, -1);
    idle_inputs();
    chk_cycle("fdvs_w1", 4'b0000, -1);
    check1("fdvs no flip", bus.sram_flip, 1'b0);
    chk_cycle("fdvs_w2", 4'b0000, -1);
    check_int("fdvs no flip yet", flip_cnt - f0, 0);
    bus.vsync = 1'b1;
    chk_cycle("fdvs_vs2", 4'b0000, -1);
    idle_inputs();
    @(negedge clk);
    check1("fdvs flip strobe", bus.sram_flip, 1'b1);
    @(posedge clk); #1;
    wait_render("flip2");
    check_int("fdvs flip count", flip_cnt - f0, 1);
    check1("flip2 front_buf", bus.front_buf, 1'b1);

    // frame_done in WAIT_SYNC: sticky overrun
    bus.frame_done = 1'b1;
    chk_cycle("ovr_fd1", 4'b0000, -1);
    chk_cycle("ovr_fd2", 4'b0000, -1);
    bus.frame_done = 1'b0;
    bus.vsync      = 1'b1;
    @(negedge clk);
    check1("overrun set", bus.overrun, 1'b1);
    @(posedge clk); #1;
    idle_inputs();
    chk_cycle("ovr_flip", 4'b0000, -1);
    wait_render("flip3");
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check1("overrun sticky", bus.overrun, 1'b1);
    check1("flip3 front_buf", bus.front_buf, 1'b0);

    // Reset clears overrun; first grant in the first cycle after release
    @(posedge clk); #1;
    n_rst = 1'b0;
    bus.req_valid = 4'b1111;
    @(negedge clk);
    check1("rst2 overrun", bus.overrun, 1'b0);
    check1("rst2 front_buf", bus.front_buf, 1'b1);
    check1("rst2 sram_we", bus.sram_we, 1'b0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    bus.req_valid = 4'b1000;
    chk_cycle("post_rst", 4'b1000, 0);
    bus.req_valid = '0;
    chk_cycle("post_rst_wr", 4'b0000, 1);

`ifdef FB_CLEAR_ON_FLIP_EN
    // Reset mid-clear at address 100 stops all further writes
    begin
      int n;
      bus.frame_done = 1'b1;
      chk_cycle("clr_fd", 4'b0000, 0);
      bus.frame_done = 1'b0;
      bus.vsync      = 1'b1;
      chk_cycle("clr_vs", 4'b0000, 0);
      idle_inputs();
      for (int a = 0; a <= 100; a++) exp_q.push_back({ADDR_SIZE'(a), CLEAR_VALUE});
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(bus.sram_we && bus.sram_addr == 8'd100) && n < 400);
      check_int("clr reached addr 100", int'(bus.sram_addr), 100);
      #2;
      n_rst = 1'b0;
      @(negedge clk);
      check1("clr_abort sram_we", bus.sram_we, 1'b0);
      @(posedge clk); #1;
      n_rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      @(negedge clk);
      check1("clr_abort busy", bus.busy, 1'b0);
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_int("scoreboard drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
